regset_access_ctrl: RTL and testbench

- Core-side controller in front of a 64-entry, 1-write/2-read synchronous register set with a grubby bit, for memories that have no preinit.
- After reset, or on request, it walks the memory and writes zero to every entry, including the grubby bit.
- In normal operation it forwards core reads and writes to the memory and adds same-cycle write-to-read bypass, so reads see write-first semantics on read-first BRAM.
- It forces address 0 to read as zero.

---
 rtl/regset_access_ctrl_if.sv | 43 ++++
 rtl/regset_access_ctrl.sv | 137 +++++++++++++
 tb/tb_regset_access_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/regset_access_ctrl_if.sv
// rtl/regset_access_ctrl_if.sv - core and memory bus bundle for regset_access_ctrl
//
// Purpose: carries the core-side access bus and the memory-side port bus of the
// 64-entry 1W/2R register set controller.
// Modports:
//   master - core/memory environment: drives clear_req, we/wa/wd/wg, ra1/ra2 and
//            the memory read data mem_rd*/mem_rg*; observes everything else
//   slave  - the controller: receives core requests and memory read data, drives
//            ready, rd*/rg*, and the memory write/read ports
interface regset_access_ctrl_if;
  logic        clear_req;
  logic        ready;
  logic        we;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic        wg;
  logic [5:0]  ra1;
  logic [5:0]  ra2;
  logic [31:0] rd1;
  logic        rg1;
  logic [31:0] rd2;
  logic        rg2;
  logic        mem_we;
  logic [5:0]  mem_wa;
  logic [31:0] mem_wd;
  logic        mem_wg;
  logic [5:0]  mem_ra1;
  logic [5:0]  mem_ra2;
  logic [31:0] mem_rd1;
  logic        mem_rg1;
  logic [31:0] mem_rd2;
  logic        mem_rg2;

  modport master (
    output clear_req, we, wa, wd, wg, ra1, ra2, mem_rd1, mem_rg1, mem_rd2, mem_rg2,
    input  ready, rd1, rg1, rd2, rg2, mem_we, mem_wa, mem_wd, mem_wg, mem_ra1, mem_ra2
  );

  modport slave (
    input  clear_req, we, wa, wd, wg, ra1, ra2, mem_rd1, mem_rg1, mem_rd2, mem_rg2,
    output ready, rd1, rg1, rd2, rg2, mem_we, mem_wa, mem_wd, mem_wg, mem_ra1, mem_ra2
  );
endinterface

// File: rtl/regset_access_ctrl.sv
// rtl/regset_access_ctrl.sv - clear sequencer and write-first bypass for a 1W/2R register set
//
// Purpose: zero-fills the register set (data and grubby bit) after reset or on
// clear_req, then forwards core accesses to the memory, adding same-cycle
// write-to-read bypass and optional hard-zero reads of address 0.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - regset_access_ctrl_if.slave (core requests, read results, memory ports)
// Parameters:
//   CLEAR_ALL - 1: clear entries 0..63; 0: clear entry 0 only
//   ZERO_X0   - 1: reads of address 0 return zero data and grubby
module regset_access_ctrl #(
  parameter bit CLEAR_ALL = 1'b1,
  parameter bit ZERO_X0   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  regset_access_ctrl_if.slave  bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_nxt;
  logic        w_ready;

  logic [5:0]  r_ra1_q;
  logic [5:0]  r_ra2_q;
  logic        r_byp_v;
  logic [5:0]  r_byp_a;
  logic [31:0] r_byp_d;
  logic        r_byp_g;

  logic [32:0] w_rsel1;
  logic [32:0] w_rsel2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ra1_q <= '0;
      r_ra2_q <= '0;
      r_byp_v <= 1'b0;
      r_byp_a <= '0;
      r_byp_d <= '0;
      r_byp_g <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ra1_q <= bus.ra1;
      r_ra2_q <= bus.ra2;
      // Only writes that actually reached the memory may be bypassed.
      r_byp_v <= bus.we & w_ready;
      r_byp_a <= bus.wa;
      r_byp_d <= bus.wd;
      r_byp_g <= bus.wg;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    bus.mem_we  = 1'b0;
    bus.mem_wa  = '0;
    bus.mem_wd  = '0;
    bus.mem_wg  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        // Core writes are dropped here; the memory port belongs to the clear walk.
        bus.mem_we = 1'b1;
        bus.mem_wa = r_cnt;
        if (bus.clear_req) begin
          w_cnt_nxt = '0;
        end else if (!CLEAR_ALL || (r_cnt == 6'd63)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      ST_RUN: begin
        w_ready    = 1'b1;
        bus.mem_we = bus.we;
        bus.mem_wa = bus.wa;
        bus.mem_wd = bus.wd;
        bus.mem_wg = bus.wg;
        if (bus.clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Read result select: hard zero beats bypass beats memory. The bypass turns
  // the read-first memory into write-first for same-cycle write/read pairs.
  function automatic logic [32:0] read_sel(
    input logic [5:0]  a,
    input logic        bv,
    input logic [5:0]  ba,
    input logic [31:0] bd,
    input logic        bg,
    input logic [31:0] md,
    input logic        mg
  );
    if (ZERO_X0 && (a == 6'd0)) begin
      read_sel = '0;
    end else if (bv && (ba == a)) begin
      read_sel = {bd, bg};
    end else begin
      read_sel = {md, mg};
    end
  endfunction

  assign w_rsel1 = read_sel(r_ra1_q, r_byp_v, r_byp_a, r_byp_d, r_byp_g, bus.mem_rd1, bus.mem_rg1);
  assign w_rsel2 = read_sel(r_ra2_q, r_byp_v, r_byp_a, r_byp_d, r_byp_g, bus.mem_rd2, bus.mem_rg2);

  assign bus.rd1     = w_rsel1[32:1];
  assign bus.rg1     = w_rsel1[0];
  assign bus.rd2     = w_rsel2[32:1];
  assign bus.rg2     = w_rsel2[0];
  assign bus.ready   = w_ready;
  assign bus.mem_ra1 = bus.ra1;
  assign bus.mem_ra2 = bus.ra2;

endmodule

// File: tb/tb_regset_access_ctrl.sv
// tb/tb_regset_access_ctrl.sv - scoreboard bench for regset_access_ctrl
module tb_regset_access_ctrl;
  logic clk = 1'b0;
  logic rst;

  regset_access_ctrl_if bus ();

  regset_access_ctrl #(.CLEAR_ALL(1'b1), .ZERO_X0(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Read-first synchronous memory with garbage contents (no preinit).
  logic [31:0] bram_d [64];
  logic        bram_g [64];
  initial begin
    for (int i = 0; i < 64; i++) begin
      bram_d[i] <= $urandom;
      bram_g[i] <= 1'($urandom_range(0, 1));
    end
  end
  always @(posedge clk) begin
    bus.mem_rd1 <= bram_d[bus.mem_ra1];
    bus.mem_rg1 <= bram_g[bus.mem_ra1];
    bus.mem_rd2 <= bram_d[bus.mem_ra2];
    bus.mem_rg2 <= bram_g[bus.mem_ra2];
    if (bus.mem_we) begin
      bram_d[bus.mem_wa] <= bus.mem_wd;
      bram_g[bus.mem_wa] <= bus.mem_wg;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    bit          ready;
    bit          chk_mem;
    logic [5:0]  clr_wa;
    bit          chk_rd;
    logic [31:0] d1;
    bit          g1;
    logic [31:0] d2;
    bit          g2;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int total = 0;
  int bad   = 0;

  // Architectural reference: register contents plus a clear-walk position.
  logic [31:0] m_d [64];
  bit          m_g [64];
  bit          m_clear = 1'b1;
  int          m_idx   = 0;

  task automatic step(input bit i_rst, input bit i_clr, input bit i_we,
                      input logic [5:0] i_wa, input logic [31:0] i_wd, input bit i_wg,
                      input logic [5:0] i_ra1, input logic [5:0] i_ra2);
    exp_t e;
    bit   pre_clear;
    rst           = i_rst;
    bus.clear_req = i_clr;
    bus.we        = i_we;
    bus.wa        = i_wa;
    bus.wd        = i_wd;
    bus.wg        = i_wg;
    bus.ra1       = i_ra1;
    bus.ra2       = i_ra2;
    pre_clear = m_clear;
    if (m_clear) begin
      m_d[m_idx] = 32'd0;
      m_g[m_idx] = 1'b0;
    end else if (i_we) begin
      m_d[i_wa] = i_wd;
      m_g[i_wa] = i_wg;
    end
    e.stamp  = cyc + 1;
    e.chk_rd = !pre_clear && !i_rst && !i_clr;
    e.d1 = (i_ra1 == 6'd0) ? 32'd0 : m_d[i_ra1];
    e.g1 = (i_ra1 == 6'd0) ? 1'b0  : m_g[i_ra1];
    e.d2 = (i_ra2 == 6'd0) ? 32'd0 : m_d[i_ra2];
    e.g2 = (i_ra2 == 6'd0) ? 1'b0  : m_g[i_ra2];
    if (i_rst || i_clr) begin
      m_clear = 1'b1;
      m_idx   = 0;
    end else if (m_clear) begin
      if (m_idx == 63) begin
        m_clear = 1'b0;
        m_idx   = 0;
      end else begin
        m_idx = m_idx + 1;
      end
    end
    e.ready   = !m_clear;
    e.chk_mem = m_clear;
    e.clr_wa  = 6'(m_idx);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0);
  endtask

  // Monitor: pops the entry due this cycle and compares it with the DUT.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].stamp < cyc) begin
        total++;
        bad++;
        $display("FAIL stale_entry stamp=%0d now=%0d", q[0].stamp, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].stamp == cyc) begin
        me = q.pop_front();
        total++;
        if (bus.ready !== me.ready) begin
          bad++;
          $display("FAIL ready cyc=%0d got=%0b exp=%0b", cyc, bus.ready, me.ready);
        end
        if (me.chk_mem) begin
          total++;
          if ({bus.mem_we, bus.mem_wa, bus.mem_wd, bus.mem_wg} !== {1'b1, me.clr_wa, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL clear_write cyc=%0d got we=%0b wa=%0d wd=%h wg=%0b exp wa=%0d",
                     cyc, bus.mem_we, bus.mem_wa, bus.mem_wd, bus.mem_wg, me.clr_wa);
          end
        end
        if (me.chk_rd) begin
          total++;
          if ({bus.rd1, bus.rg1} !== {me.d1, me.g1}) begin
            bad++;
            $display("FAIL read1 cyc=%0d got=%h/%0b exp=%h/%0b", cyc, bus.rd1, bus.rg1, me.d1, me.g1);
          end
          total++;
          if ({bus.rd2, bus.rg2} !== {me.d2, me.g2}) begin
            bad++;
            $display("FAIL read2 cyc=%0d got=%h/%0b exp=%h/%0b", cyc, bus.rd2, bus.rg2, me.d2, me.g2);
          end
        end
      end
    end
  end

  initial begin
    logic [5:0] wa;
    logic [5:0] ra1;
    for (int i = 0; i < 64; i++) begin
      m_d[i] = 32'd0;
      m_g[i] = 1'b0;
    end
    rst = 1'b1;
    bus.clear_req = 1'b0;
    bus.we = 1'b0;
    bus.wa = '0;
    bus.wd = '0;
    bus.wg = 1'b0;
    bus.ra1 = '0;
    bus.ra2 = '0;
    @(posedge clk);
    #1;

    // Reset, full clear walk, then a read of a cleared entry.
    step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0);
    repeat (64) idle();
    step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd17, 6'd17);

    // Same-cycle write/read bypass, then the same read from memory.
    step(1'b0, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 6'd5, 6'd4);
    idle();
    step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd5, 6'd5);

    // Address 0 reads as zero even after a write.
    step(1'b0, 1'b0, 1'b1, 6'd0, 32'h12345678, 1'b1, 6'd0, 6'd0);
    step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0);

    // Port 1 bypasses while port 2 reads memory.
    step(1'b0, 1'b0, 1'b1, 6'd10, 32'h1, 1'b0, 6'd1, 6'd2);
    step(1'b0, 1'b0, 1'b1, 6'd9, 32'hA5A5A5A5, 1'b0, 6'd9, 6'd10);
    step(1'b0, 1'b0, 1'b1, 6'd11, 32'h55, 1'b1, 6'd11, 6'd11);

    // clear_req with core writes hammering during the walk.
    step(1'b0, 1'b0, 1'b1, 6'd3, 32'h77, 1'b0, 6'd3, 6'd0);
    step(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd3, 6'd3);
    repeat (64) step(1'b0, 1'b0, 1'b1, 6'($urandom_range(0, 63)), $urandom, 1'b1, 6'd3, 6'd3);
    step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd3, 6'd5);

    // Reset in the middle of a clear walk restarts it.
    step(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0);
    repeat (20) idle();
    step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0);
    repeat (64) idle();

    // Randomized traffic with occasional clears and resets.
    for (int n = 0; n < 1500; n++) begin
      wa  = 6'($urandom_range(0, 63));
      ra1 = ($urandom_range(0, 9) < 4) ? wa : 6'($urandom_range(0, 63));
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 149) == 0),
           1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)),
           ra1, ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63)));
    end
    idle();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout left=%0d", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
